fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Parameters
REQ-001 SHALL provide ADDR_WIDTH, default 32, fetch address width in bits.
REQ-002 SHALL provide DATA_WIDTH, default 32, instruction word width in bits.
REQ-003 SHALL provide NUM_PORTS, default 2, number of fetch ports; legal range 1..8.

Interface
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rreq_i  input  NUM_PORTS  per-port request valid; bit k qualifies slot k of raddr_i.
REQ-007 raddr_i  input  NUM_PORTS*ADDR_WIDTH  packed fetch addresses; slot k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 flush_i  input  1  abort the current bundle; no response is produced for it.
REQ-009 stallreq_o  output  1  high while a new bundle cannot be accepted.
REQ-010 rvalid_o  output  NUM_PORTS  per-port response valid, one-cycle pulse.
REQ-011 raddr_o  output  NUM_PORTS*ADDR_WIDTH  echoed request addresses.
REQ-012 rdata_o  output  NUM_PORTS*DATA_WIDTH  fetched instruction words.
REQ-013 axi_req_o  output  1  memory read request.
REQ-014 axi_addr_o  output  ADDR_WIDTH  memory read address.
REQ-015 axi_rvalid_i  input  1  read data valid; completes the outstanding request.
REQ-016 axi_rdata_i  input  DATA_WIDTH  read data.

Function
REQ-017 SHALL implement the states IDLE, FETCH, RESP and DRAIN.
REQ-018 IDLE: stallreq_o=0; if |rreq_i and !flush_i, SHALL latch raddr_i, latch rreq_i as both the pending mask and the original mask, set idx to the lowest set bit, and go to FETCH; otherwise stay in IDLE.
REQ-019 A port with rreq_i=0 SHALL NOT be fetched, whatever its address value; address 0 is a legal fetch.
REQ-020 FETCH: axi_req_o=1 and axi_addr_o=latched addr[idx], both stable until axi_rvalid_i; at most one request outstanding.
REQ-021 FETCH with axi_rvalid_i: store axi_rdata_i into buf[idx] and clear pending[idx]; if pending is still nonzero, set idx to the next lowest set bit and stay in FETCH (next request issued the following cycle); otherwise go to RESP.
REQ-022 RESP: hold for exactly one cycle; rvalid_o = original mask; raddr_o and rdata_o driven for valid slots; then go to IDLE.
REQ-023 Responses SHALL be all-or-nothing per bundle: no partial rvalid_o.
REQ-024 flush_i in FETCH with axi_rvalid_i in the same cycle: discard the data and go to IDLE.
REQ-025 flush_i in FETCH without axi_rvalid_i: go to DRAIN.
REQ-026 DRAIN: keep axi_req_o=1 with the same address; on axi_rvalid_i, discard the data and go to IDLE; further flush_i has no effect.
REQ-027 flush_i in RESP: force rvalid_o=0 and go to IDLE.
REQ-028 flush_i in IDLE: the cycle's rreq_i SHALL be ignored.
REQ-029 stallreq_o SHALL be 1 in FETCH, RESP and DRAIN.
REQ-030 axi_addr_o SHALL be 0 whenever axi_req_o=0.
REQ-031 Output slots with rvalid_o bit k = 0 SHALL read 0 in both raddr_o and rdata_o.
REQ-032 idx width SHALL be max(1, $clog2(NUM_PORTS)).
REQ-033 axi_rvalid_i in IDLE or RESP SHALL be ignored.

Reset
REQ-034 rst_n low SHALL immediately force the state to IDLE and clear the masks, idx, buffers and latched addresses.
REQ-035 During reset: stallreq_o=0, axi_req_o=0, axi_addr_o=0, and rvalid_o, raddr_o and rdata_o are 0.
REQ-036 Reset asserted mid-FETCH SHALL abandon the outstanding request without draining.

Verification
REQ-037 NUM_PORTS=2, rreq_i=2'b11, addrs 0x1C000000/0x1C000004, rvalid after 3 cycles each -> two requests in that order; one RESP cycle with rvalid_o=2'b11 and matching data.
REQ-038 rreq_i=2'b10, addr slot1=0x1C000008, slot0=0x0 -> exactly one request to 0x1C000008; rvalid_o=2'b10; slot0 outputs 0.
REQ-039 rreq_i=2'b01, addr 0x0 -> one request to address 0x0, response delivered (address 0 is legal).
REQ-040 flush_i during the first FETCH wait -> DRAIN, axi_req_o held until axi_rvalid_i, then IDLE; rvalid_o never asserted.
REQ-041 flush_i coincident with the final axi_rvalid_i -> IDLE next cycle; no RESP pulse.
REQ-042 NUM_PORTS=4, rreq_i=4'b1010 with back-to-back rvalid, then rst_n pulsed mid-second fetch -> all outputs 0 immediately; a fresh request is accepted after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-port instruction fetch sequencer.
// Latches a bundle of up to NUM_PORTS fetch requests and serialises them onto a
// single-outstanding memory read channel, lowest port first. It then presents the
// whole bundle for one cycle. A flush aborts the bundle; if a read is already in
// flight, the sequencer waits for that read to return before going idle.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             rreq_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  raddr_i,
  input  logic                             flush_i,
  output logic                             stallreq_o,
  output logic [NUM_PORTS-1:0]             rvalid_o,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]  raddr_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o,
  output logic                             axi_req_o,
  output logic [ADDR_WIDTH-1:0]            axi_addr_o,
  input  logic                             axi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            axi_rdata_i
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_PORTS-1:0]  pend_q, pend_d;
  logic [NUM_PORTS-1:0]  orig_q, orig_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_d [NUM_PORTS];
  logic [DATA_WIDTH-1:0] buf_q  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] buf_d  [NUM_PORTS];

  logic [NUM_PORTS-1:0]  idx_onehot;
  logic [NUM_PORTS-1:0]  pend_after;

  // Index of the lowest set bit; ports are always served in ascending order.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_PORTS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Pending mask with the port currently being fetched removed.
  always_comb begin
    idx_onehot = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_onehot[k] = (idx_q == IDX_W'(k));
    end
    pend_after = pend_q & ~idx_onehot;
  end

  // Sequencing: accept a bundle, walk its pending ports one read at a time, then respond or abort.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    orig_d  = orig_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if ((|rreq_i) && !flush_i) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            addr_d[k] = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          end
          pend_d  = rreq_i;
          orig_d  = rreq_i;
          idx_d   = lowest_set(rreq_i);
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (axi_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            buf_d[idx_q] = axi_rdata_i;
            pend_d       = pend_after;
            if (|pend_after) begin
              idx_d = lowest_set(pend_after);
            end else begin
              state_d = RESP;
            end
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (axi_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, masks, index, and latched address/data storage; reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      orig_q  <= '0;
      idx_q   <= '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        addr_q[k] <= '0;
        buf_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      orig_q  <= orig_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  assign stallreq_o = (state_q != IDLE);
  assign axi_req_o  = (state_q == FETCH) || (state_q == DRAIN);
  assign axi_addr_o = axi_req_o ? addr_q[idx_q] : '0;
  assign rvalid_o   = ((state_q == RESP) && !flush_i) ? orig_q : '0;

  // Response slots are zeroed unless their valid bit is set.
  always_comb begin
    raddr_o = '0;
    rdata_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rvalid_o[k]) begin
        raddr_o[k*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[k];
        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = buf_q[k];
      end
    end
  end

endmodule
